// File: rtl/cordic_act_unit.sv
// Neuron activation unit: sigmoid/tanh via hyperbolic CORDIC + linear-vectoring divide, ReLU/leaky direct.
// Optional macro ACT_CLAMP_EN clamps sigmoid/tanh inputs to [-1.0,+1.0] before the CORDIC.
module cordic_act_unit #(
    parameter int WIDTH      = 15,
    parameter int FRAC       = 10,
    parameter int ITER       = 14,
    parameter int GUARD      = 3,
    parameter int KINV       = 1236,
    parameter int LEAK_SHIFT = 3
) (
    input  logic             clk,
    input  logic             ext_reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:0]   in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_data,
    output logic             out_oor,
    output logic             busy
);
    localparam int IW     = WIDTH + 1 + GUARD + 2;
    localparam int SC     = FRAC + GUARD;
    localparam int HSTEPS = ITER + ((ITER >= 4) ? 1 : 0) + ((ITER >= 13) ? 1 : 0);
    localparam int CW     = $clog2(HSTEPS);

    localparam logic signed [IW-1:0]  ONE_I = IW'(1 << SC);
    localparam logic signed [IW-1:0]  ONE_O = IW'(1 << FRAC);
    localparam logic signed [IW-1:0]  NEG_O = -ONE_O;
    localparam logic signed [WIDTH:0] ONE_Z = (WIDTH+1)'(1 << FRAC);
    localparam logic signed [WIDTH:0] NEG_Z = -ONE_Z;

    typedef enum logic [2:0] {IDLE, HYP, PREP, DIV, DONE} state_t;

    state_t                  state, state_nx;
    logic signed [WIDTH:0]   z_r, zc;
    logic [1:0]              mode_r;
    logic signed [IW-1:0]    x, y, w, x_h, y_h, w_h, q_s;
    logic [CW-1:0]           cnt;
    logic [WIDTH:0]          res;
    int                      hk;

    // atanh(2^-k) held at 2^16 scale, rescaled to the internal 2^(FRAC+GUARD) format
    function automatic logic signed [IW-1:0] atanh_c(input int k);
        int t16;
        case (k)
            1:       t16 = 35999;
            2:       t16 = 16739;
            3:       t16 = 8235;
            4:       t16 = 4101;
            5:       t16 = 2049;
            6:       t16 = 1024;
            default: t16 = (k <= 16) ? (1 << (16 - k)) : 0;
        endcase
        if (SC >= 16) return IW'(t16 << (SC - 16));
        else          return IW'((t16 + (1 << (15 - SC))) >>> (16 - SC));
    endfunction

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge ext_reset) begin
        if (ext_reset) state <= IDLE;
        else           state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = in_mode[1] ? DONE : HYP;
            HYP:     if (cnt == CW'(HSTEPS - 1)) state_nx = PREP;
            PREP:    state_nx = DIV;
            DIV:     if (cnt == CW'(ITER - 1)) state_nx = DONE;
            DONE:    if (out_valid && out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        zc = in_data;
`ifdef ACT_CLAMP_EN
        if (!in_mode[1]) begin
            if (zc > ONE_Z)      zc = ONE_Z;
            else if (zc < NEG_Z) zc = NEG_Z;
        end
`endif
    end

    // shift sequence 1,2,3,4,4,5,...,13,13,14 so the hyperbolic iteration converges
    always_comb begin
        hk = int'(cnt) + 1 - ((int'(cnt) >= 4) ? 1 : 0)
                           - ((ITER >= 13 && int'(cnt) >= 14) ? 1 : 0);
        if (!w[IW-1]) begin
            x_h = x + (y >>> hk);
            y_h = y + (x >>> hk);
            w_h = w - atanh_c(hk);
        end else begin
            x_h = x - (y >>> hk);
            y_h = y - (x >>> hk);
            w_h = w + atanh_c(hk);
        end
    end

    always_comb begin
        res = '0;
        q_s = w >>> GUARD;
        case (mode_r)
            2'b00: begin
                if (q_s[IW-1])       res = '0;
                else if (q_s > ONE_O) res = ONE_O[WIDTH:0];
                else                  res = q_s[WIDTH:0];
            end
            2'b01: begin
                if (q_s < NEG_O)      res = NEG_O[WIDTH:0];
                else if (q_s > ONE_O) res = ONE_O[WIDTH:0];
                else                  res = q_s[WIDTH:0];
            end
            2'b10: begin
                if (z_r[WIDTH]) res = '0;
                else            res = z_r;
            end
            default: begin
                if (z_r[WIDTH]) res = z_r >>> LEAK_SHIFT;
                else            res = z_r;
            end
        endcase
    end

    // x/y/w are reused: cosh/sinh/angle in HYP, den/residual/quotient in DIV
    always_ff @(posedge clk or posedge ext_reset) begin
        if (ext_reset) begin
            z_r       <= '0;
            mode_r    <= '0;
            x         <= '0;
            y         <= '0;
            w         <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_oor   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    z_r     <= $signed(in_data);
                    mode_r  <= in_mode;
                    out_oor <= ($signed(in_data) > ONE_Z) || ($signed(in_data) < NEG_Z);
                    x       <= IW'(KINV << GUARD);
                    y       <= '0;
                    w       <= $signed({{(IW-WIDTH-1){zc[WIDTH]}}, zc}) <<< GUARD;
                    cnt     <= '0;
                end
                HYP: begin
                    x   <= x_h;
                    y   <= y_h;
                    w   <= w_h;
                    cnt <= (cnt == CW'(HSTEPS - 1)) ? '0 : cnt + 1'b1;
                end
                PREP: begin
                    if (!mode_r[0]) begin
                        y <= x + y;
                        x <= x + y + ONE_I;
                    end
                    w <= '0;
                end
                DIV: begin
                    if (!y[IW-1]) begin
                        y <= y - (x >>> cnt);
                        w <= w + (ONE_I >>> cnt);
                    end else begin
                        y <= y + (x >>> cnt);
                        w <= w - (ONE_I >>> cnt);
                    end
                    cnt <= cnt + 1'b1;
                end
                DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_data  <= res;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cordic_act_unit.sv
// Directed bench for cordic_act_unit with hand-computed expectations (CORDIC results +/-2 LSB).
module tb_cordic_act_unit;
    localparam int WIDTH = 15;

    logic             clk = 1'b0;
    logic             ext_reset, in_valid, in_ready, out_valid, out_ready, out_oor, busy;
    logic [WIDTH:0]   in_data, out_data;
    logic [1:0]       in_mode;
    int               errors = 0, checks = 0;
    int               res, oor, lat, hold_d;

    always #5 clk = ~clk;

    cordic_act_unit dut (
        .clk       (clk),
        .ext_reset (ext_reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_oor   (out_oor),
        .busy      (busy)
    );

    task automatic chk(input string tag, input int got, input int exp, input int tol = 0);
        checks++;
        if (got > exp + tol || got < exp - tol) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    task automatic start_op(input logic [1:0] m, input int z);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("ready_wait", int'(in_ready), 1);
        @(negedge clk);
        in_data  = z[WIDTH:0];
        in_mode  = m;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int r, output int o, output int l);
        l = 0;
        while (!out_valid && l < 200) begin
            @(posedge clk); #1; l++;
        end
        chk("out_valid_seen", int'(out_valid), 1);
        r = int'($signed(out_data));
        o = int'(out_oor);
    endtask

    task automatic ack();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic op(input logic [1:0] m, input int z, output int r, output int o, output int l);
        start_op(m, z);
        wait_out(r, o, l);
        ack();
    endtask

    initial begin
        ext_reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_mode = '0;
        #2;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready",  int'(in_ready), 1);
        chk("rst_busy",      int'(busy), 0);
        chk("rst_out_data",  int'(out_data), 0);
        chk("rst_out_oor",   int'(out_oor), 0);
        @(negedge clk); @(negedge clk);
        ext_reset = 1'b0;

        op(2'b01, 0, res, oor, lat);
        chk("tanh0_val", res, 0, 2);
        chk("tanh0_oor", oor, 0);
        chk("tanh0_lat", lat, 32);
        chk("post_ack_valid", int'(out_valid), 0);
        chk("post_ack_ready", int'(in_ready), 1);

        op(2'b00, 0, res, oor, lat);
        chk("sig0_val", res, 512, 2);
        op(2'b00, 1024, res, oor, lat);
        chk("sig1_val", res, 749, 2);
        chk("sig1_oor", oor, 0);
        op(2'b01, 512, res, oor, lat);
        chk("tanh_p05", res, 473, 2);
        op(2'b01, -512, res, oor, lat);
        chk("tanh_m05", res, -473, 2);

        op(2'b10, 'hF400, res, oor, lat);
        chk("relu_neg_val", res, 0);
        chk("relu_neg_lat", lat, 1);
        chk("relu_neg_oor", oor, 1);
        op(2'b11, -1024, res, oor, lat);
        chk("leaky_neg_val", res, -128);
        chk("leaky_neg_oor", oor, 0);
        op(2'b10, 300, res, oor, lat);
        chk("relu_pos_val", res, 300);
        op(2'b11, 200, res, oor, lat);
        chk("leaky_pos_val", res, 200);

        // backpressure: result held while a second request is presented and ignored
        start_op(2'b01, 512);
        wait_out(hold_d, oor, lat);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 16'd77; in_mode = 2'b10;
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_data",  int'($signed(out_data)), hold_d);
        chk("hold_ready", int'(in_ready), 0);
        chk("hold_val_ok", hold_d, 473, 2);
        ack();
        chk("hold_ack_valid", int'(out_valid), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("ignored_req", int'(out_valid), 0);
        chk("ignored_busy", int'(busy), 0);

        // reset during DIV discards the computation
        start_op(2'b00, 1024);
        repeat (25) @(posedge clk);
        @(negedge clk);
        ext_reset = 1'b1;
        #1;
        chk("midrst_valid", int'(out_valid), 0);
        chk("midrst_data",  int'(out_data), 0);
        chk("midrst_ready", int'(in_ready), 1);
        @(negedge clk);
        ext_reset = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("midrst_no_out", int'(out_valid), 0);
        op(2'b00, 0, res, oor, lat);
        chk("after_rst_sig0", res, 512, 2);
        chk("after_rst_lat", lat, 32);

        op(2'b01, 2048, res, oor, lat);
        chk("tanh2_oor", oor, 1);
`ifdef ACT_CLAMP_EN
        chk("tanh2_clamped", res, 780, 2);
`else
        chk("tanh2_in_range", int'(res >= -1024 && res <= 1024), 1);
`endif
        op(2'b00, -2048, res, oor, lat);
        chk("sigm2_oor", oor, 1);
        chk("sigm2_in_range", int'(res >= 0 && res <= 1024), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
